mdu_unit: RTL
=============

// Module: mdu_unit
// PURPOSE
//   Multiply/divide unit of the E stage, directly upstream of the E/M pipeline register.
//   Executes MULT/MULTU/DIV/DIVU over a fixed number of cycles into private HI/LO registers.
//   Serves MFHI/MFLO (result muxed into the E-stage ALU result path) and MTHI/MTLO.
//   Exports busy so the D-stage hazard logic stalls any MDU instruction while an operation is in flight.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for MULT/MULTU/MADD/MADDU (range 1..15)
//   DIV_CYCLES   10  busy cycles for DIV/DIVU (range 1..15)
// PORTS
//   clk         in   1   rising-edge clock
//   reset       in   1   asynchronous, active-low reset (0 = reset asserted)
//   mdu_start   in   1   E-stage instruction is a valid MDU op this cycle
//   mdu_op      in   4   0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,7 MTHI,8 MTLO,9 MADD,10 MADDU
//   rs_val      in   32  forwarded rs operand (dividend / multiplicand / MTHI/MTLO source)
//   rt_val      in   32  forwarded rt operand (divisor / multiplier)
//   busy        out  1   operation in flight
//   hi_out      out  32  HI register
//   lo_out      out  32  LO register
//   mdu_result  out  32  combinational: hi_out for MFHI, lo_out for MFLO, else 0
// BEHAVIOUR
//   - Reset (reset==0, any time, asynchronous): state IDLE, counter 0, busy=0, hi_out=lo_out=0.
//     Operand latches cleared; an in-flight op is discarded, no HI/LO write.
//   - Op acceptance: sampled on a rising edge only when mdu_start=1 and state==IDLE.
//   - FSM IDLE: MULT/MULTU/MADD/MADDU -> MUL, counter=MULT_CYCLES.
//     DIV/DIVU -> DIV, counter=DIV_CYCLES. Operands latched at the same edge.
//   - FSM MUL/DIV: counter decrements each edge. On the edge where counter==1: write HI/LO,
//     return to IDLE, busy drops.
//   - busy is registered, = (state!=IDLE). Start sampled at edge 0 -> busy=1 for exactly
//     N cycles -> new HI/LO and busy=0 visible together after edge N.
//   - MFHI/MFLO: combinational read of current registers, valid only while busy=0.
//   - MTHI/MTLO: write HI/LO = rs_val at the accepting edge, zero latency; other register unchanged.
//   - Starts while busy=1 are ignored, including MT*, MF*, and MADD: state, registers and
//     counter unchanged. The hazard unit guarantees none arrive.
//   - mdu_start=1 with NOP or opcode 11..15: no effect.
//   - MULT: {HI,LO} = $signed(rs)*$signed(rt), 64-bit. MULTU: unsigned 64-bit product.
//   - DIV: LO = quotient truncated toward zero, HI = remainder carrying the dividend's sign.
//     DIVU: unsigned quotient/remainder.
//   - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//   - Divide by zero (rt_val==0, DIV or DIVU): full DIV_CYCLES busy, then HI/LO unchanged.
//   - Result computed from latched operands; rs_val/rt_val changes during busy have no effect.
// CONFIGURATION
//   MDU_MADD_EN defined: opcode 9 MADD, {HI,LO} += signed product;
//     opcode 10 MADDU, {HI,LO} += unsigned product.
//     Both are modulo 2^64, use MULT_CYCLES, and add to the HI/LO value present at the final edge.
//   MDU_MADD_EN undefined: opcodes 9/10 are treated as NOP; no accumulate adder synthesised.
// TESTING
//   1. reset=0 during DIV at cycle 4 -> busy=0 immediately, hi_out=lo_out=0;
//      after release, MFLO reads 0.
//   2. MULT rs=0xFFFFFFFE rt=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA;
//      MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
//   3. DIV rs=-7 (0xFFFFFFF9) rt=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF;
//      DIVU 7/2 -> LO=3, HI=1.
//   4. MTHI 0x1234 then DIV rt=0 -> busy 10 cycles, then HI=0x1234, LO unchanged.
//      DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//   5. MTLO 0xAAAA issued with mdu_start during MULT busy -> ignored, LO = product.
//      MFLO with busy=0 -> mdu_result=lo_out the same cycle.
//   6. MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU 1*1 -> HI=1, LO=0.
//      Without the macro, op 9 leaves HI/LO unchanged and busy stays 0.

Source files
------------

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: fixed-latency MULT/MULTU/DIV/DIVU into private HI/LO, plus MFHI/MFLO/MTHI/MTLO.
// Optional MADD/MADDU accumulate (opcodes 9/10) is built only when MDU_MADD_EN is defined.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdu_start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] mdu_result
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
`endif

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] rs_q, rs_d;
    logic [31:0] rt_q, rt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;

    logic        start_mul;
    logic        start_div;

    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_prod;
    logic [63:0] mul_res;

    logic        div_signed;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    // Only an idle unit accepts work; anything arriving while busy is dropped.
    always_comb begin
        start_mul = 1'b0;
        start_div = 1'b0;
        if (mdu_start && (state_q == S_IDLE)) begin
            case (mdu_op)
                OP_MULT, OP_MULTU: start_mul = 1'b1;
`ifdef MDU_MADD_EN
                OP_MADD, OP_MADDU: start_mul = 1'b1;
`endif
                OP_DIV, OP_DIVU:   start_div = 1'b1;
                default: ;
            endcase
        end
    end

    // Both operands extended to 64 bits so the low 64 product bits are exact for either signedness.
    always_comb begin
        mul_signed = (op_q == OP_MULT);
`ifdef MDU_MADD_EN
        mul_signed = mul_signed || (op_q == OP_MADD);
`endif
        mul_a    = mul_signed ? {{32{rs_q[31]}}, rs_q} : {32'd0, rs_q};
        mul_b    = mul_signed ? {{32{rt_q[31]}}, rt_q} : {32'd0, rt_q};
        mul_prod = mul_a * mul_b;
`ifdef MDU_MADD_EN
        if ((op_q == OP_MADD) || (op_q == OP_MADDU)) begin
            mul_res = {hi_q, lo_q} + mul_prod;
        end else begin
            mul_res = mul_prod;
        end
`else
        mul_res = mul_prod;
`endif
    end

    // Signed divide via magnitudes: 0x80000000 / -1 falls out as 0x80000000 rem 0 without overflow.
    always_comb begin
        div_signed = (op_q == OP_DIV);
        rs_neg     = div_signed && rs_q[31];
        rt_neg     = div_signed && rt_q[31];
        rs_mag     = rs_neg ? (32'd0 - rs_q) : rs_q;
        rt_mag     = rt_neg ? (32'd0 - rt_q) : rt_q;
        quo_mag    = '0;
        rem_mag    = '0;
        if (rt_mag != 32'd0) begin
            quo_mag = rs_mag / rt_mag;
            rem_mag = rs_mag % rt_mag;
        end
        quo = (rs_neg ^ rt_neg) ? (32'd0 - quo_mag) : quo_mag;
        rem = rs_neg ? (32'd0 - rem_mag) : rem_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start_mul || start_div) begin
                    state_d = start_mul ? S_MUL : S_DIV;
                    cnt_d   = start_mul ? MULT_CNT : DIV_CNT;
                    op_d    = mdu_op;
                    rs_d    = rs_val;
                    rt_d    = rt_val;
                end else if (mdu_start && (mdu_op == OP_MTHI)) begin
                    hi_d = rs_val;
                end else if (mdu_start && (mdu_op == OP_MTLO)) begin
                    lo_d = rs_val;
                end
            end
            S_MUL: begin
                if (cnt_q == 4'd1) begin
                    {hi_d, lo_d} = mul_res;
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DIV: begin
                if (cnt_q == 4'd1) begin
                    // Divide by zero burns the full latency but leaves HI/LO alone.
                    if (rt_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        mdu_result = '0;
        if (mdu_op == OP_MFHI) begin
            mdu_result = hi_q;
        end else if (mdu_op == OP_MFLO) begin
            mdu_result = lo_q;
        end
    end

    assign busy   = busy_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule
